// File: rtl/clk_freq_meter.sv
//==============================================================================
// Module   : clk_freq_meter
// Function : Counts rising edges of an asynchronous test clock over a fixed
//            sys_clk gate window and reports the count and an in-range flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module clk_freq_meter #(
    parameter int unsigned       GATE_CYCLES = 50_000_000,
    parameter int unsigned       CNT_W       = 32,
    parameter logic [CNT_W-1:0]  FREQ_MIN    = '0,
    parameter logic [CNT_W-1:0]  FREQ_MAX    = '1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clk_test,
    input  logic             meas_en,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             freq_valid,
    output logic             freq_ok,
    output logic             busy
);

    localparam int unsigned    GW      = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]  LAST    = GW'(GATE_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t state_q, state_d;

    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic s1_q;
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic s2_q;
    logic s3_q;

    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] freq_cnt_q, freq_cnt_d;
    logic             freq_ok_q, freq_ok_d;
    logic             freq_valid_q, freq_valid_d;

    logic             rise;
    logic             last;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] sat;
    logic             in_range;

    // Synchronizer runs in every state so window start never sees a stale edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= clk_test;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign last = (state_q == GATE) && (gate_cnt_q == LAST);
    assign sum  = {1'b0, edge_cnt_q} + {{CNT_W{1'b0}}, rise};
    assign sat  = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    // Compared one bit wider so the default full-range bounds stay well formed
    assign in_range = (({1'b0, sat} + {{CNT_W{1'b0}}, 1'b1}) > {1'b0, FREQ_MIN}) &&
                      ({1'b0, sat} < ({1'b0, FREQ_MAX} + {{CNT_W{1'b0}}, 1'b1}));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            freq_cnt_q   <= '0;
            freq_ok_q    <= 1'b0;
            freq_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            freq_cnt_q   <= freq_cnt_d;
            freq_ok_q    <= freq_ok_d;
            freq_valid_q <= freq_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        freq_cnt_d   = freq_cnt_q;
        freq_ok_d    = freq_ok_q;
        freq_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                if (meas_en) begin
                    state_d = GATE;
                end
            end
            GATE: begin
                if (last) begin
                    // The edge seen on the closing cycle belongs to this window
                    freq_cnt_d   = sat;
                    freq_ok_d    = in_range;
                    freq_valid_d = 1'b1;
                    gate_cnt_d   = '0;
                    edge_cnt_d   = '0;
                    state_d      = meas_en ? GATE : IDLE;
                end else if (!meas_en) begin
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                    edge_cnt_d = sat;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign freq_cnt   = freq_cnt_q;
    assign freq_ok    = freq_ok_q;
    assign freq_valid = freq_valid_q;
    assign busy       = (state_q == GATE);

endmodule

`default_nettype wire

// File: tb/tb_clk_freq_meter.sv
//==============================================================================
// Module   : tb_clk_freq_meter
// Function : Directed, table-driven bench for clk_freq_meter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_clk_freq_meter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        clk_test;
    logic        clk_test_b;
    logic        meas_en;
    logic [31:0] freq_cnt;
    logic        freq_valid;
    logic        freq_ok;
    logic        busy;
    logic [3:0]  freq_cnt_b;
    logic        freq_valid_b;
    logic        freq_ok_b;
    logic        busy_b;

    int mode = 1;
    int phase = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int mode;
        int cnt;
        bit ok;
    } vec_t;

    vec_t vecs[4];

    always #5 sys_clk = ~sys_clk;

    // Stimulus changes on the falling edge, away from the sampling edge
    always @(negedge sys_clk) begin
        phase = phase + 1;
        clk_test   = (mode == 1) ? phase[1] : (mode == 2) ? phase[0] : 1'b0;
        clk_test_b = phase[1];
    end

    clk_freq_meter #(
        .GATE_CYCLES(100),
        .CNT_W      (32),
        .FREQ_MIN   (32'd20),
        .FREQ_MAX   (32'd30)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clk_test  (clk_test),
        .meas_en   (meas_en),
        .freq_cnt  (freq_cnt),
        .freq_valid(freq_valid),
        .freq_ok   (freq_ok),
        .busy      (busy)
    );

    clk_freq_meter #(
        .GATE_CYCLES(100),
        .CNT_W      (4)
    ) u_dut_narrow (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clk_test  (clk_test_b),
        .meas_en   (meas_en),
        .freq_cnt  (freq_cnt_b),
        .freq_valid(freq_valid_b),
        .freq_ok   (freq_ok_b),
        .busy      (busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Cycles until freq_valid (wide instance), bounded by limit
    task automatic wait_valid(input int limit, output int n, output bit seen, output bit dropped);
        n = 0;
        dropped = 1'b0;
        do begin
            tick();
            n++;
            if (!busy) dropped = 1'b1;
        end while (!freq_valid && n < limit);
        seen = freq_valid;
    endtask

    int n;
    bit seen;
    bit dropped;

    initial begin
        vecs[0] = '{mode: 1, cnt: 25, ok: 1'b1};
        vecs[1] = '{mode: 0, cnt: 0,  ok: 1'b0};
        vecs[2] = '{mode: 2, cnt: 50, ok: 1'b0};
        vecs[3] = '{mode: 1, cnt: 25, ok: 1'b1};

        sys_rst = 1'b1;
        meas_en = 1'b0;
        repeat (3) tick();
        chk("reset freq_cnt",   freq_cnt,   0);
        chk("reset freq_valid", freq_valid, 0);
        chk("reset freq_ok",    freq_ok,    0);
        chk("reset busy",       busy,       0);

        sys_rst = 1'b0;
        meas_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            wait_valid(250, n, seen, dropped);
            chk($sformatf("vec%0d first pulse seen", i), seen, 1);
            wait_valid(250, n, seen, dropped);
            chk($sformatf("vec%0d pulse interval", i), n, 100);
            chk($sformatf("vec%0d freq_cnt", i), freq_cnt, vecs[i].cnt);
            chk($sformatf("vec%0d freq_ok", i), freq_ok, vecs[i].ok);
            chk($sformatf("vec%0d busy held", i), dropped, 0);
            tick();
            chk($sformatf("vec%0d valid one cycle", i), freq_valid, 0);
        end

        // Abort: drop meas_en at cycle 40 of the window after a 25-count result
        mode = 1;
        wait_valid(250, n, seen, dropped);
        chk("abort prior cnt", freq_cnt, 25);
        repeat (39) tick();
        meas_en = 1'b0;
        tick();
        chk("abort busy low", busy, 0);
        wait_valid(150, n, seen, dropped);
        chk("abort no valid", seen, 0);
        chk("abort cnt held", freq_cnt, 25);
        chk("abort ok held", freq_ok, 1);
        meas_en = 1'b1;
        tick();
        chk("rearm busy", busy, 1);
        wait_valid(250, n, seen, dropped);
        chk("rearm interval", n, 100);
        chk("rearm cnt", freq_cnt, 25);

        // One-cycle reset in the middle of a window
        repeat (30) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("midrst freq_cnt",   freq_cnt,   0);
        chk("midrst freq_valid", freq_valid, 0);
        chk("midrst freq_ok",    freq_ok,    0);
        chk("midrst busy",       busy,       0);
        tick();
        chk("postrst busy", busy, 1);
        wait_valid(250, n, seen, dropped);
        chk("postrst interval", n, 100);
        chk("postrst cnt", freq_cnt, 25);
        chk("postrst ok", freq_ok, 1);

        // Narrow counter: 25 edges must clamp at 15 rather than wrap to 9
        n = 0;
        do begin
            tick();
            n++;
        end while (!freq_valid_b && n < 250);
        chk("narrow pulse seen", freq_valid_b, 1);
        chk("narrow saturate", freq_cnt_b, 15);
        chk("narrow ok", freq_ok_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clk_freq_meter.md
# clk_freq_meter

Measures the frequency of one clock-like signal. The signal typically comes from a clock-wizard output, a divided clock or a test pin. It is counted over a fixed gate window of `sys_clk` cycles, and the block reports the edge count and an in-range flag. It sits beside the clock generation logic as an on-chip checker, and its outputs feed status LEDs, a UART report or a debug probe. The measured signal is treated as asynchronous data, so the block runs entirely in the `sys_clk` domain.

## Interface

Parameters:
- `GATE_CYCLES`, default 50_000_000: gate window length in `sys_clk` cycles (1 s at 50 MHz). Must be ≥ 2.
- `CNT_W`, default 32: width of the edge counter and of `freq_cnt`.
- `FREQ_MIN`, default 0: lowest count accepted as in range.
- `FREQ_MAX`, default 2^CNT_W-1: highest count accepted as in range.

Ports:
- `sys_clk`, input, 1: the single block clock.
- `sys_rst`, input, 1: synchronous reset, active-high.
- `clk_test`, input, 1: signal under measurement. Asynchronous to `sys_clk`. Its frequency must be below `sys_clk`/2.
- `meas_en`, input, 1: while high, the block measures continuously. Dropping it low aborts the current window.
- `freq_cnt`, output, CNT_W: rising-edge count of the last completed window.
- `freq_valid`, output, 1: one-cycle pulse when `freq_cnt` updates.
- `freq_ok`, output, 1: `FREQ_MIN` ≤ `freq_cnt` ≤ `FREQ_MAX` for the last completed window.
- `busy`, output, 1: high while a gate window is open.

## Operation

- Input path:
  - `clk_test` passes through a 2-FF synchronizer (s1, s2) and then a delay register s3.
  - A rising edge is `rise = s2 & ~s3`.
  - The synchronizer flops carry a no-touch/ASYNC_REG attribute.
- State machine:
  - IDLE → GATE when `meas_en` = 1.
  - GATE → GATE on the last gate cycle if `meas_en` = 1, opening the next window back-to-back.
  - GATE → IDLE on the last gate cycle if `meas_en` = 0.
  - GATE → IDLE on any cycle where `meas_en` = 0, which aborts the window.
- Gate counter:
  - Counts 0..`GATE_CYCLES`-1 while in GATE.
  - The last gate cycle is the cycle with count = `GATE_CYCLES`-1.
  - Clears on entry to GATE and on every window restart.
- Edge counter:
  - Adds `rise` on every GATE cycle.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Clears at each window start.
- On the last gate cycle:
  - `freq_cnt` ← edge count plus `rise`, saturated. An edge seen on the last cycle belongs to the closing window.
  - `freq_ok` ← range compare of that same value.
  - `freq_valid` pulses.
- Abort (`meas_en` low mid-window): no `freq_valid` pulse. `freq_cnt` and `freq_ok` hold the result of the previous completed window.
- `busy` = 1 exactly when the state is GATE.
- The synchronizer (s1..s3) keeps running in IDLE, so a stale edge is never counted at window start.

## Timing

- Reset values:
  - `freq_cnt` = 0, `freq_valid` = 0, `freq_ok` = 0, `busy` = 0.
  - State is IDLE; all counters and s1..s3 are 0.
- Reset has priority over every other event. Asserting `sys_rst` mid-window discards the window, and all outputs are at reset values on the following cycle.
- Window timing:
  - `meas_en` is sampled high in IDLE at edge N, so `busy` = 1 from cycle N+1.
  - The window covers cycles N+1 .. N+`GATE_CYCLES`.
  - `freq_valid` and the new `freq_cnt`/`freq_ok` appear in cycle N+`GATE_CYCLES`+1.
  - In continuous mode that same cycle is the first cycle of the next window. Windows have no gaps, and no edge is lost or double-counted.
- Edge latency: a `clk_test` transition reaches `rise` 2–3 `sys_clk` cycles later. This gives ±1 count uncertainty for asynchronous input.
- `freq_valid` is high for exactly one cycle per completed window, never two in a row, because `GATE_CYCLES` ≥ 2.

## Test plan

- `GATE_CYCLES`=100, `FREQ_MIN`=20, `FREQ_MAX`=30. `clk_test` toggles every 2 `sys_clk` cycles (period 4), `meas_en` held high.
  - → `freq_valid` pulses every 100 cycles, `freq_cnt`=25, `freq_ok`=1, `busy` continuously 1.
- Same parameters with `clk_test` held low.
  - → `freq_cnt`=0 and `freq_ok`=0 on each pulse.
- Same parameters with `clk_test` period 2 (toggle every cycle).
  - → `freq_cnt`=50, `freq_ok`=0.
- `CNT_W`=4 with the period-4 stimulus.
  - → `freq_cnt` saturates at 15 and does not wrap to 9.
- Abort case: complete one window (`freq_cnt`=25), then start a second window and drop `meas_en` at cycle 40 of it.
  - → no `freq_valid`, `freq_cnt` stays 25, `busy`=0 next cycle.
  - Re-raising `meas_en` gives the next pulse exactly 100 cycles later.
- Assert `sys_rst` for one cycle mid-window.
  - → all outputs 0 the next cycle.
  - With `meas_en` still high, `busy` returns the cycle after reset releases, and the first `freq_valid` comes 100 cycles after that.
